// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the byte-serial load/store unit and the write-back
// load-extension logic.
//   F3_*        : RV32I funct3 encodings for loads/stores
//   lsu_state_t : LSU sequencing states
//   beats_for() : number of byte beats needed for a given funct3
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

  // Access size in bytes, taken from the funct3 size bits. Encodings that are
  // illegal never reach a memory beat, so their value here is irrelevant.
  function automatic logic [2:0] beats_for(input logic [2:0] funct3);
    case (funct3)
      F3_H, F3_HU: beats_for = 3'd2;
      F3_W:        beats_for = 3'd4;
      default:     beats_for = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Combinational load-result formatter: takes a little-endian assembled word
// and produces the RV32I load result for the given funct3.
//   funct3 : RV32I load funct3 (LB/LH/LW/LBU/LHU)
//   word   : assembled memory word, byte 0 in bits [7:0]
//   result : sign/zero-extended load data (0 for non-load encodings)
// -----------------------------------------------------------------------------
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_W:    result = word;
      F3_BU:   result = {24'b0, word[7:0]};
      F3_HU:   result = {16'b0, word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// -----------------------------------------------------------------------------
// lsu_byte_serial
// RV32I load/store unit that performs each access as 1, 2 or 4 sequential
// little-endian byte beats on a byte-wide memory port.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only while idle)
//   req_store, req_funct3      : access type and RV32I funct3
//   req_addr, req_wdata        : effective byte address, store data
//   resp_valid                 : one-cycle completion pulse
//   resp_rdata, resp_err       : extended load data, illegal/misaligned flag
//   mem_valid/mem_ready        : byte beat handshake
//   mem_we, mem_addr           : beat direction and byte address
//   mem_wdata, mem_rdata       : write byte, read byte
//
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses are
//                          rejected with resp_err instead of being split across
//                          the alignment boundary.
// -----------------------------------------------------------------------------
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t  state_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;

  logic        legal;
  logic        misaligned;
  logic [1:0]  next_cnt;
  logic [31:0] asm_next;
  logic [31:0] ext_result;
  logic        unused_addr_hi;

  // Only the low ADDR_W address bits reach the memory port.
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign next_cnt = cnt_q + 2'd1;

  // Decide whether an incoming request may touch memory at all.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (req_store) begin
      legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (beats_for(req_funct3) == 3'd2) begin
      misaligned = req_addr[0];
    end else if (beats_for(req_funct3) == 3'd4) begin
      misaligned = |req_addr[1:0];
    end
`endif
  end

  // Assembly word including the byte arriving this cycle, so the final beat
  // can be extended and registered into resp_rdata on the same edge.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = mem_rdata;
  end

  lsu_load_extend u_load_extend (
    .funct3 (funct3_q),
    .word   (asm_next),
    .result (ext_result)
  );

  // Sequencer. All port outputs are registered here; the memory address is
  // held in mem_addr itself and stepped by one (mod 2^ADDR_W) per beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata;
            asm_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 2'(beats_for(req_funct3) - 3'd1);
            req_ready <= 1'b0;
            if (!legal || misaligned) begin
              state_q    <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q   <= ACCESS;
              mem_valid <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= req_addr[ADDR_W-1:0];
              mem_wdata <= req_wdata[7:0];
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            asm_q <= asm_next;
            cnt_q <= next_cnt;
            if (cnt_q == last_q) begin
              state_q    <= DONE;
              mem_valid  <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_wdata  <= '0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= store_q ? 32'd0 : ext_result;
            end else begin
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= wdata_q[{next_cnt, 3'b000} +: 8];
            end
          end
        end

        DONE: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
